sd_card_spi_cmd_sequencer: RTL and testbench
============================================

Name: sd_card_spi_cmd_sequencer

Overview:
Sequences the SD-card SPI byte-transfer engine to issue one complete SPI-mode SD command. Each command is SS assert, optional 0xFF preamble, 6-byte command frame, R1 response polling, SS release and 0xFF trailer bytes. It sits between the SD init/read/write control FSMs and the byte-transfer engine, and owns the SS line. It drives the engine through the init_trans/byte_done handshake, one byte at a time.

Parameters:
PRE_BYTES, 1, number of 0xFF bytes sent with SS low before the command frame (0..15)
RESP_MAX_BYTES, 8, maximum number of 0xFF poll bytes while waiting for R1 (NCR limit, 1..255)
POST_BYTES, 1, number of 0xFF bytes sent with SS high after the response (0..15)

Ports:
clk210_p  in  1  210 MHz system clock
reset_n_p  in  1  asynchronous active-low reset
cmd_start_p  in  1  single-cycle request to issue a command; sampled only in IDLE
cmd_index_p  in  6  command index, latched on accepted start
cmd_arg_p  in  32  command argument, latched on accepted start
cmd_crc_p  in  7  CRC7, latched on accepted start
cmd_busy_p  out  1  high from accepted start until the cycle of cmd_done_p inclusive
cmd_done_p  out  1  one-cycle pulse when the sequence completes
cmd_r1_p  out  8  R1 response byte, valid from cmd_done_p until the next accepted start
cmd_timeout_p  out  1  set with cmd_done_p if no R1 arrived within RESP_MAX_BYTES; cleared on next accepted start
sd_spi_ss_p  out  1  SD chip select, active low
byte_init_trans_p  out  1  request to the byte engine to transfer byte_tx_p
byte_tx_p  out  8  byte to transmit, stable while byte_init_trans_p is high
byte_rx_p  in  8  byte received by the engine, valid when byte_done_p is high
byte_done_p  in  1  byte engine completion flag; stays high until byte_init_trans_p drops

Behaviour:
- Reset (async, reset_n_p=0): state IDLE; sd_spi_ss_p=1, byte_init_trans_p=0, byte_tx_p=8'hFF, cmd_busy_p=0, cmd_done_p=0, cmd_r1_p=8'hFF, cmd_timeout_p=0, all counters 0.
- A reset asserted mid-sequence aborts it immediately: SS goes high, init drops, no cmd_done_p pulse.
- Byte handshake (every byte):
  - Assert byte_init_trans_p with byte_tx_p only when byte_done_p=0.
  - Hold both until byte_done_p=1, then capture byte_rx_p and drop byte_init_trans_p in the same edge.
  - Wait for byte_done_p=0 before the next assertion.
  - The engine's SCK speed is not this block's concern.
- Frame bytes, in order:
  - F0={2'b01,cmd_index}
  - F1..F4=cmd_arg[31:24],[23:16],[15:8],[7:0]
  - F5={cmd_crc,1'b1}
- States:
  - IDLE: cmd_start_p=1 → latch inputs, cmd_busy_p=1, cmd_timeout_p=0, sd_spi_ss_p=0, go to PRE (or FRAME if PRE_BYTES=0). A start seen outside IDLE is ignored.
  - PRE: send 0xFF PRE_BYTES times; received data is discarded. Then go to FRAME.
  - FRAME: send F0..F5 using a 3-bit index; received data is discarded. After F5 completes, go to POLL with poll count 0.
  - POLL: send 0xFF and increment the poll count on each completed byte.
    - If byte_rx_p[7]=0: cmd_r1_p<=byte_rx_p, go to RELEASE.
    - Else if count reaches RESP_MAX_BYTES: cmd_r1_p<=8'hFF, cmd_timeout_p<=1, go to RELEASE.
  - RELEASE: sd_spi_ss_p<=1 for one cycle. Then go to POST (or DONE if POST_BYTES=0).
  - POST: send 0xFF POST_BYTES times with SS high.
  - DONE: cmd_done_p=1 for exactly one cycle; cmd_busy_p drops the following cycle; return to IDLE.
- R1 detection uses only bit 7. An R1 on the first poll byte is legal; the minimum poll count is 1.
- Counters are wide enough that RESP_MAX_BYTES=255 is exact with no wrap.
- byte_tx_p returns to 8'hFF in IDLE.
- SS never toggles while byte_init_trans_p=1.
- Total byte count per command = PRE_BYTES+6+polls+POST_BYTES.

Test Plan:
- CMD0, arg 0, crc 7'h4A, defaults; slave returns FF,01 on poll bytes → TX stream FF,40,00,00,00,00,95,FF,FF,FF; cmd_r1_p=8'h01; cmd_timeout_p=0; exactly 2 poll bytes; one cmd_done_p pulse.
- CMD8, arg 32'h000001AA, crc 7'h43; first poll returns 01 → frame 48,00,00,01,AA,87; cmd_r1_p=8'h01; SS low only from the first PRE byte through the poll byte.
- Slave always returns FF, RESP_MAX_BYTES=8 → exactly 8 poll bytes; cmd_r1_p=8'hFF; cmd_timeout_p=1 with done; 1 POST byte with SS high.
- Engine model holds byte_done_p high for 5 cycles after init drops → no byte_init_trans_p re-assertion until byte_done_p=0; no byte skipped or duplicated.
- cmd_start_p pulsed during FRAME with different index → ignored; original command completes unchanged; cmd_busy_p stays high.
- reset_n_p low during POLL → same cycle: sd_spi_ss_p=1, byte_init_trans_p=0, cmd_busy_p=0; no cmd_done_p; a new start after release runs a clean full sequence.

Source files
------------

// File: rtl/sd_card_spi_cmd_sequencer.sv
// ----------------------------------------------------------------------------
// sd_card_spi_cmd_sequencer
//
// Issues one complete SPI-mode SD command through a byte-transfer engine:
// SS assert, PRE_BYTES x 0xFF, 6-byte command frame, R1 polling (up to
// RESP_MAX_BYTES), SS release, POST_BYTES x 0xFF with SS high.
//
// Ports:
//   clk210_p, reset_n_p          system clock, async active-low reset
//   cmd_start_p                  start request (honoured only in IDLE)
//   cmd_index_p/arg_p/crc_p      command fields, latched on accepted start
//   cmd_busy_p, cmd_done_p       sequence in progress / one-cycle completion
//   cmd_r1_p, cmd_timeout_p      R1 result and NCR timeout flag
//   sd_spi_ss_p                  SD chip select (active low)
//   byte_init_trans_p/tx_p       byte request and data to the engine
//   byte_rx_p, byte_done_p       received byte and completion from the engine
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module sd_card_spi_cmd_sequencer #(
    parameter int PRE_BYTES      = 1,
    parameter int RESP_MAX_BYTES = 8,
    parameter int POST_BYTES     = 1
) (
    input  logic        clk210_p,
    input  logic        reset_n_p,
    input  logic        cmd_start_p,
    input  logic [5:0]  cmd_index_p,
    input  logic [31:0] cmd_arg_p,
    input  logic [6:0]  cmd_crc_p,
    output logic        cmd_busy_p,
    output logic        cmd_done_p,
    output logic [7:0]  cmd_r1_p,
    output logic        cmd_timeout_p,
    output logic        sd_spi_ss_p,
    output logic        byte_init_trans_p,
    output logic [7:0]  byte_tx_p,
    input  logic [7:0]  byte_rx_p,
    input  logic        byte_done_p
);

    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_FRAME, S_POLL, S_RELEASE, S_POST, S_DONE
    } state_t;

    // 8-bit counters cover PRE/POST (<=15) and RESP_MAX_BYTES up to 255 exactly.
    localparam logic [7:0] PRE_N  = 8'(PRE_BYTES);
    localparam logic [7:0] RESP_N = 8'(RESP_MAX_BYTES);
    localparam logic [7:0] POST_N = 8'(POST_BYTES);

    state_t      state_q, state_d;
    logic        init_q, init_d;
    logic [7:0]  tx_q, tx_d;
    logic        ss_q, ss_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [7:0]  r1_q, r1_d;
    logic        timeout_q, timeout_d;
    logic [5:0]  index_q, index_d;
    logic [31:0] arg_q, arg_d;
    logic [6:0]  crc_q, crc_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [2:0]  fidx_q, fidx_d;

    logic        can_issue;
    logic        xfer_done;
    logic [7:0]  cnt_inc;

    function automatic logic [7:0] frame_byte(input logic [2:0] idx,
                                              input logic [5:0] ci,
                                              input logic [31:0] a,
                                              input logic [6:0] c);
        logic [7:0] b;
        case (idx)
            3'd0:    b = {2'b01, ci};
            3'd1:    b = a[31:24];
            3'd2:    b = a[23:16];
            3'd3:    b = a[15:8];
            3'd4:    b = a[7:0];
            default: b = {c, 1'b1};
        endcase
        return b;
    endfunction

    always_comb begin
        state_d   = state_q;
        init_d    = init_q;
        tx_d      = tx_q;
        ss_d      = ss_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        r1_d      = r1_q;
        timeout_d = timeout_q;
        index_d   = index_q;
        arg_d     = arg_q;
        crc_d     = crc_q;
        cnt_d     = cnt_q;
        fidx_d    = fidx_q;

        // A new byte may only start once the engine has released byte_done.
        can_issue = !init_q && !byte_done_p;
        xfer_done = init_q && byte_done_p;
        cnt_inc   = cnt_q + 8'd1;

        case (state_q)
            S_IDLE: begin
                tx_d = 8'hFF;
                if (cmd_start_p) begin
                    index_d   = cmd_index_p;
                    arg_d     = cmd_arg_p;
                    crc_d     = cmd_crc_p;
                    busy_d    = 1'b1;
                    timeout_d = 1'b0;
                    ss_d      = 1'b0;
                    cnt_d     = 8'd0;
                    fidx_d    = 3'd0;
                    state_d   = (PRE_N != 8'd0) ? S_PRE : S_FRAME;
                end
            end
            S_PRE: begin
                if (can_issue) begin
                    init_d = 1'b1;
                    tx_d   = 8'hFF;
                end else if (xfer_done) begin
                    init_d = 1'b0;
                    cnt_d  = cnt_inc;
                    if (cnt_inc == PRE_N) begin
                        cnt_d   = 8'd0;
                        state_d = S_FRAME;
                    end
                end
            end
            S_FRAME: begin
                if (can_issue) begin
                    init_d = 1'b1;
                    tx_d   = frame_byte(fidx_q, index_q, arg_q, crc_q);
                end else if (xfer_done) begin
                    init_d = 1'b0;
                    if (fidx_q == 3'd5) begin
                        cnt_d   = 8'd0;
                        state_d = S_POLL;
                    end else begin
                        fidx_d = fidx_q + 3'd1;
                    end
                end
            end
            S_POLL: begin
                if (can_issue) begin
                    init_d = 1'b1;
                    tx_d   = 8'hFF;
                end else if (xfer_done) begin
                    init_d = 1'b0;
                    cnt_d  = cnt_inc;
                    // Only bit 7 distinguishes an R1 from idle-high line data.
                    if (!byte_rx_p[7]) begin
                        r1_d    = byte_rx_p;
                        state_d = S_RELEASE;
                    end else if (cnt_inc == RESP_N) begin
                        r1_d      = 8'hFF;
                        timeout_d = 1'b1;
                        state_d   = S_RELEASE;
                    end
                end
            end
            S_RELEASE: begin
                // SS rises here, with init already low, so it never moves mid-byte.
                ss_d  = 1'b1;
                cnt_d = 8'd0;
                if (POST_N != 8'd0) begin
                    state_d = S_POST;
                end else begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_POST: begin
                if (can_issue) begin
                    init_d = 1'b1;
                    tx_d   = 8'hFF;
                end else if (xfer_done) begin
                    init_d = 1'b0;
                    cnt_d  = cnt_inc;
                    if (cnt_inc == POST_N) begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                tx_d    = 8'hFF;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk210_p or negedge reset_n_p) begin
        if (!reset_n_p) begin
            state_q   <= S_IDLE;
            init_q    <= 1'b0;
            tx_q      <= 8'hFF;
            ss_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            r1_q      <= 8'hFF;
            timeout_q <= 1'b0;
            index_q   <= 6'd0;
            arg_q     <= 32'd0;
            crc_q     <= 7'd0;
            cnt_q     <= 8'd0;
            fidx_q    <= 3'd0;
        end else begin
            state_q   <= state_d;
            init_q    <= init_d;
            tx_q      <= tx_d;
            ss_q      <= ss_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            r1_q      <= r1_d;
            timeout_q <= timeout_d;
            index_q   <= index_d;
            arg_q     <= arg_d;
            crc_q     <= crc_d;
            cnt_q     <= cnt_d;
            fidx_q    <= fidx_d;
        end
    end

    assign cmd_busy_p        = busy_q;
    assign cmd_done_p        = done_q;
    assign cmd_r1_p          = r1_q;
    assign cmd_timeout_p     = timeout_q;
    assign sd_spi_ss_p       = ss_q;
    assign byte_init_trans_p = init_q;
    assign byte_tx_p         = tx_q;

endmodule

// File: tb/tb_sd_card_spi_cmd_sequencer.sv
`timescale 1ns/1ps
module tb_sd_card_spi_cmd_sequencer;

    logic        clk;
    logic        reset_n;
    logic        cmd_start;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    logic [6:0]  cmd_crc;
    logic        cmd_busy;
    logic        cmd_done;
    logic [7:0]  cmd_r1;
    logic        cmd_timeout;
    logic        ss;
    logic        init;
    logic [7:0]  tx;
    logic [7:0]  rx;
    logic        bdone;

    sd_card_spi_cmd_sequencer #(
        .PRE_BYTES(1), .RESP_MAX_BYTES(8), .POST_BYTES(1)
    ) dut (
        .clk210_p(clk), .reset_n_p(reset_n),
        .cmd_start_p(cmd_start), .cmd_index_p(cmd_index),
        .cmd_arg_p(cmd_arg), .cmd_crc_p(cmd_crc),
        .cmd_busy_p(cmd_busy), .cmd_done_p(cmd_done),
        .cmd_r1_p(cmd_r1), .cmd_timeout_p(cmd_timeout),
        .sd_spi_ss_p(ss), .byte_init_trans_p(init), .byte_tx_p(tx),
        .byte_rx_p(rx), .byte_done_p(bdone)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- byte engine model ----------------
    logic [7:0] tx_log [64];
    logic       ss_log [64];
    logic [7:0] rx_tab [64];
    int eng_n    = 0;
    int eng_hold = 0;
    int est      = 0;
    int hcnt     = 0;

    initial begin
        bdone = 1'b0;
        rx    = 8'h00;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                bdone = 1'b0;
                est   = 0;
            end else begin
                case (est)
                    0: if (init && !bdone) begin
                        if (eng_n < 64) begin
                            tx_log[eng_n] = tx;
                            ss_log[eng_n] = ss;
                        end
                        est = 1;
                    end
                    1: begin
                        rx    = (eng_n < 64) ? rx_tab[eng_n] : 8'hFF;
                        bdone = 1'b1;
                        eng_n++;
                        est   = 2;
                    end
                    2: if (!init) begin
                        if (eng_hold == 0) begin
                            bdone = 1'b0;
                            est   = 0;
                        end else begin
                            hcnt = eng_hold;
                            est  = 3;
                        end
                    end
                    default: begin
                        hcnt--;
                        if (hcnt == 0) begin
                            bdone = 1'b0;
                            est   = 0;
                        end
                    end
                endcase
            end
        end
    end

    // Handshake/SS protocol monitor, sampled mid-high-phase after each edge.
    int   viol = 0;
    int   done_cnt = 0;
    logic prev_init = 1'b0;
    logic prev_ss = 1'b1;
    logic [7:0] prev_tx = 8'hFF;
    initial begin
        forever begin
            @(posedge clk);
            #4;
            if (reset_n) begin
                if (init && !prev_init && bdone) viol++;
                if (init && prev_init && tx != prev_tx) viol++;
                if ((init || prev_init) && ss != prev_ss) viol++;
                if (cmd_done) done_cnt++;
            end
            prev_init = init;
            prev_ss   = ss;
            prev_tx   = tx;
        end
    end

    task automatic fill_rx(input int r1_at, input logic [7:0] r1v);
        for (int n = 0; n < 64; n++) begin
            if (n == 0) rx_tab[n] = 8'hFF;
            else if (n <= 6) rx_tab[n] = 8'h00;
            else if (r1_at != 0 && (n - 6) == r1_at) rx_tab[n] = r1v;
            else if (r1_at != 0 && (n - 6) > r1_at) rx_tab[n] = 8'h00;
            else rx_tab[n] = 8'hFF;
        end
    endtask

    task automatic wait_engine_idle();
        for (int c = 0; c < 100; c++) begin
            if (!bdone && est == 0) break;
            @(negedge clk);
        end
    endtask

    task automatic issue_start(input logic [5:0] idx, input logic [31:0] a, input logic [6:0] c);
        wait_engine_idle();
        eng_n = 0;
        viol  = 0;
        @(negedge clk);
        cmd_index = idx;
        cmd_arg   = a;
        cmd_crc   = c;
        cmd_start = 1'b1;
        @(negedge clk);
        cmd_start = 1'b0;
        check("busy_after_start", {31'd0, cmd_busy}, 32'd1);
    endtask

    task automatic finish_cmd(input string tag);
        int dc0;
        bit seen;
        dc0  = done_cnt;
        seen = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (cmd_done) begin
                seen = 1;
                break;
            end
        end
        check({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
        check({tag, "_busy_at_done"}, {31'd0, cmd_busy}, 32'd1);
        @(negedge clk);
        check({tag, "_busy_after_done"}, {31'd0, cmd_busy}, 32'd0);
        repeat (8) @(negedge clk);
        check({tag, "_one_done_pulse"}, done_cnt - dc0, 32'd1);
        check({tag, "_ss_idle"}, {31'd0, ss}, 32'd1);
        check({tag, "_tx_idle"}, {24'd0, tx}, 32'hFF);
        check({tag, "_handshake_viol"}, viol, 32'd0);
    endtask

    typedef struct {
        logic [5:0]  idx;
        logic [31:0] arg;
        logic [6:0]  crc;
        int          r1_at;
        logic [7:0]  r1_val;
        int          hold;
        logic [47:0] frame;
        logic [7:0]  exp_r1;
        logic        exp_to;
        int          exp_polls;
    } vec_t;

    vec_t vecs [6];

    initial begin
        vecs[0] = '{6'd0,  32'h0000_0000, 7'h4A, 2, 8'h01, 0, 48'h40_00_00_00_00_95, 8'h01, 1'b0, 2};
        vecs[1] = '{6'd8,  32'h0000_01AA, 7'h43, 1, 8'h01, 0, 48'h48_00_00_01_AA_87, 8'h01, 1'b0, 1};
        vecs[2] = '{6'd17, 32'h1234_5678, 7'h2A, 0, 8'h00, 2, 48'h51_12_34_56_78_55, 8'hFF, 1'b1, 8};
        vecs[3] = '{6'h37, 32'hDEAD_BEEF, 7'h7F, 3, 8'h05, 5, 48'h77_DE_AD_BE_EF_FF, 8'h05, 1'b0, 3};
        vecs[4] = '{6'h3F, 32'hFFFF_FFFF, 7'h00, 8, 8'h7E, 1, 48'h7F_FF_FF_FF_FF_01, 8'h7E, 1'b0, 8};
        vecs[5] = '{6'd41, 32'h4000_0000, 7'h3B, 1, 8'h00, 0, 48'h69_40_00_00_00_77, 8'h00, 1'b0, 1};

        reset_n   = 1'b0;
        cmd_start = 1'b0;
        cmd_index = 6'd0;
        cmd_arg   = 32'd0;
        cmd_crc   = 7'd0;
        fill_rx(0, 8'hFF);
        repeat (3) @(negedge clk);
        check("rst_ss", {31'd0, ss}, 32'd1);
        check("rst_init", {31'd0, init}, 32'd0);
        check("rst_tx", {24'd0, tx}, 32'hFF);
        check("rst_busy", {31'd0, cmd_busy}, 32'd0);
        check("rst_done", {31'd0, cmd_done}, 32'd0);
        check("rst_r1", {24'd0, cmd_r1}, 32'hFF);
        check("rst_timeout", {31'd0, cmd_timeout}, 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // ---------------- table-driven commands ----------------
        for (int v = 0; v < 6; v++) begin
            int nt;
            fill_rx(vecs[v].r1_at, vecs[v].r1_val);
            eng_hold = vecs[v].hold;
            issue_start(vecs[v].idx, vecs[v].arg, vecs[v].crc);
            finish_cmd($sformatf("v%0d", v));
            nt = 8 + vecs[v].exp_polls;
            check($sformatf("v%0d_byte_count", v), eng_n, nt);
            check($sformatf("v%0d_r1", v), {24'd0, cmd_r1}, {24'd0, vecs[v].exp_r1});
            check($sformatf("v%0d_timeout", v), {31'd0, cmd_timeout}, {31'd0, vecs[v].exp_to});
            for (int j = 0; j < nt && j < 64; j++) begin
                logic [7:0] et;
                logic       es;
                et = (j >= 1 && j <= 6) ? vecs[v].frame[8*(6-j) +: 8] : 8'hFF;
                es = (j < 7 + vecs[v].exp_polls) ? 1'b0 : 1'b1;
                check($sformatf("v%0d_tx%0d", v, j), {24'd0, tx_log[j]}, {24'd0, et});
                check($sformatf("v%0d_ss%0d", v, j), {31'd0, ss_log[j]}, {31'd0, es});
            end
        end

        // ---------------- start pulsed during FRAME is ignored ----------------
        eng_hold = 0;
        fill_rx(2, 8'h01);
        issue_start(6'd0, 32'd0, 7'h4A);
        for (int c = 0; c < 200 && eng_n < 3; c++) @(negedge clk);
        check("mid_frame_reached", {31'd0, (eng_n >= 3)}, 32'd1);
        cmd_index = 6'h3F;
        cmd_arg   = 32'hFFFF_FFFF;
        cmd_crc   = 7'h7F;
        cmd_start = 1'b1;
        @(negedge clk);
        cmd_start = 1'b0;
        check("mid_frame_busy", {31'd0, cmd_busy}, 32'd1);
        finish_cmd("midstart");
        check("midstart_count", eng_n, 32'd10);
        check("midstart_f0", {24'd0, tx_log[1]}, 32'h40);
        check("midstart_f4", {24'd0, tx_log[5]}, 32'h00);
        check("midstart_f5", {24'd0, tx_log[6]}, 32'h95);
        check("midstart_r1", {24'd0, cmd_r1}, 32'h01);

        // ---------------- reset during POLL aborts the command ----------------
        begin
            int dc0;
            fill_rx(0, 8'hFF);
            eng_hold = 0;
            issue_start(6'd17, 32'h1234_5678, 7'h2A);
            for (int c = 0; c < 300 && !(eng_n >= 8 && init); c++) @(negedge clk);
            check("abort_in_poll", {31'd0, (eng_n >= 8 && init)}, 32'd1);
            dc0 = done_cnt;
            reset_n = 1'b0;
            #1;
            check("abort_ss", {31'd0, ss}, 32'd1);
            check("abort_init", {31'd0, init}, 32'd0);
            check("abort_busy", {31'd0, cmd_busy}, 32'd0);
            repeat (4) @(negedge clk);
            check("abort_no_done", done_cnt - dc0, 32'd0);
            reset_n = 1'b1;
            repeat (2) @(negedge clk);
            fill_rx(2, 8'h01);
            issue_start(6'd0, 32'd0, 7'h4A);
            finish_cmd("post_abort");
            check("post_abort_count", eng_n, 32'd10);
            check("post_abort_f0", {24'd0, tx_log[1]}, 32'h40);
            check("post_abort_f5", {24'd0, tx_log[6]}, 32'h95);
            check("post_abort_r1", {24'd0, cmd_r1}, 32'h01);
            check("post_abort_to", {31'd0, cmd_timeout}, 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
